uart_chan_gate_ctrl: RTL

UART_CHAN_GATE_CTRL -- requirements
Module: uart_chan_gate_ctrl

---
 rtl/uart_ctrl_pkg.sv | 7 +
 rtl/uart_chan_gate.sv | 18 +
 rtl/uart_chan_gate_ctrl.sv | 70 +++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared FSM state type and default sizing for the UART channel gate controller.
package uart_ctrl_pkg;
  typedef enum logic {HOLD, RUN} state_t;
  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int HOLD_CYCLES_DEF = 255;
endpackage

// File: rtl/uart_chan_gate.sv
// uart_chan_gate: one channel's read gate, holding open through a frame in progress after enable drops.
module uart_chan_gate (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic ready,
  input  logic en,
  input  logic rx_busy,
  input  logic rx_read,
  output logic rx_read_buf,
  output logic draining
);
  logic g_q, g_d;
  always_comb g_d = (clear || !ready) ? 1'b0 : (en || (rx_busy && g_q));
  always_ff @(posedge clock) g_q <= reset ? 1'b0 : g_d;
  assign draining = g_q & ~en & rx_busy;
  assign rx_read_buf = rx_read & g_q;
endmodule

// File: rtl/uart_chan_gate_ctrl.sv
// uart_chan_gate_ctrl: hold-off timer gating per-channel UART read strobes until the link settles.
module uart_chan_gate_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              restart,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] rx_busy,
  input  logic [NUM_CH-1:0] rx_read,
  output logic [NUM_CH-1:0] rx_read_buf,
  output logic              ready,
  output logic              reset_en_ctl,
  output logic [NUM_CH-1:0] draining
);
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
    $error("NUM_CH out of range 1..16");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_hold
    $error("HOLD_CYCLES out of range 1..2**CNT_W-1");
  end
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pulse_q, pulse_d;
  // The counter freezes at LAST once RUN is reached, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pulse_d = 1'b0;
    if (restart) begin
      state_d = HOLD;
      cnt_d = '0;
    end else if (state_q == HOLD) begin
      state_d = (cnt_q == LAST) ? RUN : HOLD;
      pulse_d = (cnt_q == LAST);
      cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HOLD;
      cnt_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
  assign ready = (state_q == RUN);
  assign reset_en_ctl = pulse_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    uart_chan_gate u_gate (
      .clock(clock),
      .reset(reset),
      .clear(restart),
      .ready(ready),
      .en(en[i]),
      .rx_busy(rx_busy[i]),
      .rx_read(rx_read[i]),
      .rx_read_buf(rx_read_buf[i]),
      .draining(draining[i])
    );
  end
endmodule
